// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with MADD/MSUB partial-product and cycle-count storage fed back to execute.
// Latency: 1 clk, all outputs registered, no combinational input->output path.
// Backpressure: stall[EX]=0 advances, stall[EX]=1/stall[MEM]=0 inserts a bubble, stall[MEM]=1 holds.
// Optional: `EX_MEM_FLUSH_EN adds a flush input that clears every output at the next edge, above any stall.
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef EX_MEM_FLUSH_EN
  input  logic                flush,
`endif
  input  logic [STALL_W-1:0]  stall,
  input  logic                ex_wreg,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic                mem_wreg,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  logic                mem_wreg_q,  mem_wreg_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_whilo_q, mem_whilo_d;
  logic [DATA_W-1:0]   mem_hi_q,    mem_hi_d;
  logic [DATA_W-1:0]   mem_lo_q,    mem_lo_d;
  logic [2*DATA_W-1:0] hilo_q,      hilo_d;
  logic [1:0]          cnt_q,       cnt_d;

  logic stall_ex;
  logic stall_mem;
  logic stall_unused;

  assign stall_ex     = stall[EX_IDX];
  assign stall_mem    = stall[MEM_IDX];
  // Only the EX and MEM stall bits matter here; the rest of the bus is intentionally ignored.
  assign stall_unused = ^stall;

  // Next-state: flush > hold (MEM stalled, incl. the ex=0/mem=1 case) > bubble > advance.
  always_comb begin
    mem_wreg_d  = mem_wreg_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_whilo_d = mem_whilo_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    hilo_d      = hilo_q;
    cnt_d       = cnt_q;

    if (stall_mem) begin
      // Hold: MEM keeps its instruction, accumulation state tracks execute.
      hilo_d = hilo_i;
      cnt_d  = cnt_i;
    end else if (stall_ex) begin
      // Bubble: NOP into MEM, but the first-cycle product must survive.
      mem_wreg_d  = 1'b0;
      mem_waddr_d = '0;
      mem_wdata_d = '0;
      mem_whilo_d = 1'b0;
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      hilo_d      = hilo_i;
      cnt_d       = cnt_i;
    end else begin
      // Advance: capture execute result; any multi-cycle accumulation is finished.
      mem_wreg_d  = ex_wreg;
      mem_waddr_d = ex_waddr;
      mem_wdata_d = ex_wdata;
      mem_whilo_d = ex_whilo;
      mem_hi_d    = ex_hi;
      mem_lo_d    = ex_lo;
      hilo_d      = '0;
      cnt_d       = 2'd0;
    end

`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      mem_wreg_d  = 1'b0;
      mem_waddr_d = '0;
      mem_wdata_d = '0;
      mem_whilo_d = 1'b0;
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      hilo_d      = '0;
      cnt_d       = 2'd0;
    end
`endif
  end

  // State registers, cleared asynchronously by active-low rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wreg_q  <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_whilo_q <= 1'b0;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      hilo_q      <= '0;
      cnt_q       <= 2'd0;
    end else begin
      mem_wreg_q  <= mem_wreg_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_whilo_q <= mem_whilo_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      hilo_q      <= hilo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_wreg  = mem_wreg_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_whilo = mem_whilo_q;
  assign mem_hi    = mem_hi_q;
  assign mem_lo    = mem_lo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule
